// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter: the arbiter
//   state type, the default address/data widths and the default ack timeout.
//
//   Contents:
//     ARB_AW_DEFAULT        default address width (bits)
//     ARB_DW_DEFAULT        default data width (bits)
//     ARB_MAX_WAIT_DEFAULT  default number of busy cycles tolerated without ack
//     ARB_WAIT_W            width of the wait counter (covers MAX_WAIT up to 255)
//     arb_state_t           IDLE / IBUSY / DBUSY / ERR
//     arb_is_busy()         true while an access is outstanding on the bus
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ARB_AW_DEFAULT       = 16;
    localparam int ARB_DW_DEFAULT       = 16;
    localparam int ARB_MAX_WAIT_DEFAULT = 15;
    localparam int ARB_WAIT_W           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    function automatic logic arb_is_busy(input arb_state_t s);
        return (s == IBUSY) || (s == DBUSY);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between the instruction-fetch stage and the
//   data-memory stage of a pipelined CPU. Data requests win over fetches when
//   both are pending. One access is in flight at a time; it is granted in IDLE,
//   held on the memory bus until mem_ack, and completed with a one-cycle valid
//   pulse on the requesting side. An access that waits MAX_WAIT busy cycles
//   without ack locks the arbiter in ERR with bus_err set until reset.
//
//   Parameters:
//     AW        address width
//     DW        data width
//     MAX_WAIT  busy cycles tolerated without mem_ack (1..255)
//
//   Ports:
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     hlt              CPU halt: no new grants while high
//     i_req, i_addr    fetch request and address
//     i_rdata, i_valid fetched word and its one-cycle valid pulse
//     d_req, d_we      data request, 1 = write / 0 = read
//     d_addr, d_wdata  data address and write data
//     d_rdata, d_valid read data and one-cycle completion pulse
//     stall            pipeline freeze to the CPU
//     mem_req, mem_we  memory request (held until ack) and write enable
//     mem_addr         memory address
//     mem_wdata        memory write data
//     mem_rdata        memory read data
//     mem_ack          one-cycle memory completion
//     bus_err          sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = ARB_AW_DEFAULT,
    parameter int DW       = ARB_DW_DEFAULT,
    parameter int MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hlt,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);

    localparam logic [ARB_WAIT_W-1:0] WAIT_LIMIT     = ARB_WAIT_W'(MAX_WAIT);
    localparam logic [ARB_WAIT_W-1:0] WAIT_LAST_BUSY = ARB_WAIT_W'(MAX_WAIT - 1);

    arb_state_t            state;
    logic [ARB_WAIT_W-1:0] wait_cnt;
    logic                  valid_now;

    assign valid_now = i_valid | d_valid;

    // A pending request is released in the cycle its result is presented.
    // The rst_n term keeps stall low while reset is held, so every output
    // reads zero during reset even if the CPU keeps a request asserted.
    assign stall = rst_n & (((i_req | d_req) & ~valid_now)
                            | arb_is_busy(state)
                            | (state == ERR));

    // mem_req and mem_we are kept as registers that mirror the busy state:
    // mem_req is high exactly in IBUSY/DBUSY, and mem_we carries the latched
    // d_we only while a data access is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every output register sits in the async reset branch so the
        // memory bus and both result ports read zero the instant rst_n falls.
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            i_rdata   <= '0;
            i_valid   <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below are
            // overridden later in the block, so valid pulses last one cycle.
            i_valid <= 1'b0;
            d_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    // mem_ack is deliberately not looked at here.
                    if (!hlt && (d_req || i_req)) begin
                        mem_req  <= 1'b1;
                        mem_addr <= d_req ? d_addr : i_addr;
                        mem_we   <= d_req & d_we;
                        if (d_req) begin
                            mem_wdata <= d_wdata;
                        end
                        wait_cnt <= '0;
                        state    <= d_req ? DBUSY : IBUSY;
                    end
                end

                IBUSY, DBUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                        if (state == DBUSY) begin
                            d_valid <= 1'b1;
                            // Writes leave the previous read data visible.
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_valid <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (wait_cnt == WAIT_LAST_BUSY) begin
                        // This was the MAX_WAIT-th busy cycle without ack.
                        wait_cnt <= WAIT_LIMIT;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ERR: begin
                    // Terminal until reset; mem_ack and requests are ignored.
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (built with MAX_WAIT = 4).
//   A transaction-level model of the arbiter's rules predicts every output;
//   one compare process checks the DUT against it on each falling edge.
//   Directed scenarios pin the model with hand-computed literals, then a
//   randomized phase drives CPU requests, halts, resets and a memory responder
//   with random latency and spurious acks.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hlt;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          bus_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    mem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hlt       (hlt),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction record plus result regs.
    // ------------------------------------------------------------------
    logic          m_busy;      // a transaction owns the memory bus
    logic          m_is_d;      // owner is the data port
    logic          m_we;        // owner is a write
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_waited;    // busy cycles elapsed without ack
    logic          m_err;
    logic [DW-1:0] m_i_rdata;
    logic [DW-1:0] m_d_rdata;
    logic          m_i_valid;
    logic          m_d_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_is_d    <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_waited  <= 0;
            m_err     <= 1'b0;
            m_i_rdata <= '0;
            m_d_rdata <= '0;
            m_i_valid <= 1'b0;
            m_d_valid <= 1'b0;
        end else begin
            m_i_valid <= 1'b0;
            m_d_valid <= 1'b0;
            if (m_err) begin
                // locked until reset
            end else if (m_busy) begin
                if (mem_ack) begin
                    m_busy <= 1'b0;
                    if (m_is_d) begin
                        m_d_valid <= 1'b1;
                        if (!m_we) m_d_rdata <= mem_rdata;
                    end else begin
                        m_i_valid <= 1'b1;
                        m_i_rdata <= mem_rdata;
                    end
                end else if (m_waited + 1 >= MAX_WAIT) begin
                    m_busy <= 1'b0;
                    m_err  <= 1'b1;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (!hlt && (i_req || d_req)) begin
                m_busy   <= 1'b1;
                m_waited <= 0;
                m_is_d   <= d_req;
                m_we     <= d_req && d_we;
                m_addr   <= d_req ? d_addr : i_addr;
                if (d_req) m_wdata <= d_wdata;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_i_valid",   32'(i_valid),   32'd0);
            check("rst_d_valid",   32'(d_valid),   32'd0);
            check("rst_i_rdata",   32'(i_rdata),   32'd0);
            check("rst_d_rdata",   32'(d_rdata),   32'd0);
            check("rst_mem_req",   32'(mem_req),   32'd0);
            check("rst_mem_we",    32'(mem_we),    32'd0);
            check("rst_mem_addr",  32'(mem_addr),  32'd0);
            check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            check("rst_bus_err",   32'(bus_err),   32'd0);
            check("rst_stall",     32'(stall),     32'd0);
        end else begin
            check("i_valid", 32'(i_valid), 32'(m_i_valid));
            check("d_valid", 32'(d_valid), 32'(m_d_valid));
            check("i_rdata", 32'(i_rdata), 32'(m_i_rdata));
            check("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
            check("mem_req", 32'(mem_req), 32'(m_busy));
            check("mem_we",  32'(mem_we),  32'(m_busy && m_we));
            check("bus_err", 32'(bus_err), 32'(m_err));
            check("stall",   32'(stall),
                  32'(((i_req || d_req) && !(m_i_valid || m_d_valid)) || m_busy || m_err));
            if (m_busy) check("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_busy && m_we) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet_inputs();
        hlt     = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        quiet_inputs();
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        tick();
        tick();
        check("init_i_valid", 32'(i_valid),  32'd0);
        check("init_mem_req", 32'(mem_req),  32'd0);
        check("init_bus_err", 32'(bus_err),  32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch 0x0010, ack on the second busy cycle with 0xBEEF.
        i_req  = 1'b1;
        i_addr = 16'h0010;
        #1 check("s1_stall_req", 32'(stall), 32'd1);
        tick();
        check("s1_mem_req",  32'(mem_req),  32'd1);
        check("s1_mem_addr", 32'(mem_addr), 32'h0010);
        check("s1_stall_busy", 32'(stall),  32'd1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("s1_i_valid", 32'(i_valid), 32'd1);
        check("s1_i_rdata", 32'(i_rdata), 32'hBEEF);
        check("s1_stall_pulse", 32'(stall), 32'd0);
        i_req = 1'b0;
        tick();
        check("s1_i_valid_once", 32'(i_valid), 32'd0);

        // Simultaneous fetch and data read: data first, fetch right after.
        i_req  = 1'b1;
        i_addr = 16'h0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0200;
        tick();
        check("s2_first_addr", 32'(mem_addr), 32'h0200);
        check("s2_first_we",   32'(mem_we),   32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h5A5A;
        tick();
        mem_ack = 1'b0;
        check("s2_d_valid", 32'(d_valid), 32'd1);
        check("s2_d_rdata", 32'(d_rdata), 32'h5A5A);
        d_req = 1'b0;
        tick();
        check("s2_second_req",  32'(mem_req),  32'd1);
        check("s2_second_addr", 32'(mem_addr), 32'h0010);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0F0F;
        tick();
        mem_ack = 1'b0;
        check("s2_i_rdata", 32'(i_rdata), 32'h0F0F);
        i_req = 1'b0;
        tick();

        // Data write: d_rdata keeps the earlier read value.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'h1234;
        tick();
        check("s3_mem_we",    32'(mem_we),    32'd1);
        check("s3_mem_wdata", 32'(mem_wdata), 32'h1234);
        check("s3_mem_addr",  32'(mem_addr),  32'h0040);
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        check("s3_d_valid", 32'(d_valid), 32'd1);
        check("s3_d_rdata_held", 32'(d_rdata), 32'h5A5A);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("s3_mem_we_after", 32'(mem_we), 32'd0);

        // Halt raised during a fetch: fetch completes, nothing new starts.
        i_req  = 1'b1;
        i_addr = 16'h0020;
        tick();
        hlt = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        check("s4_i_valid", 32'(i_valid), 32'd1);
        check("s4_i_rdata", 32'(i_rdata), 32'h7777);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("s4_no_req_halted", 32'(mem_req), 32'd0);
        end
        hlt = 1'b0;
        tick();
        check("s4_req_after_halt", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        i_req   = 1'b0;
        tick();

        // Ack on the last tolerated busy cycle: no timeout.
        i_req  = 1'b1;
        i_addr = 16'h0030;
        tick();
        for (int k = 0; k < MAX_WAIT - 1; k++) tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'h4444;
        tick();
        mem_ack = 1'b0;
        check("s5b_i_valid", 32'(i_valid), 32'd1);
        check("s5b_bus_err", 32'(bus_err), 32'd0);
        i_req = 1'b0;
        tick();

        // No ack: ERR after MAX_WAIT busy cycles, sticky until reset.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0300;
        tick();
        for (int k = 0; k < MAX_WAIT - 1; k++) begin
            tick();
            check("s5_no_err_yet", 32'(bus_err), 32'd0);
            check("s5_req_held",   32'(mem_req), 32'd1);
        end
        tick();
        check("s5_bus_err", 32'(bus_err), 32'd1);
        check("s5_req_off", 32'(mem_req), 32'd0);
        check("s5_stall",   32'(stall),   32'd1);
        d_req   = 1'b0;
        mem_ack = 1'b1;
        #1 check("s5_stall_no_req", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        check("s5_late_ack_ignored", 32'(d_valid), 32'd0);
        tick();
        tick();
        check("s5_bus_err_sticky", 32'(bus_err), 32'd1);
        check("s5_stall_sticky",   32'(stall),   32'd1);
        rst_n = 1'b0;
        #1 check("s5_err_cleared", 32'(bus_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a data read.
        d_req  = 1'b1;
        d_addr = 16'h0400;
        tick();
        check("s6_busy",      32'(mem_req),  32'd1);
        check("s6_busy_addr", 32'(mem_addr), 32'h0400);
        rst_n = 1'b0;
        #1;
        check("s6_mem_req",   32'(mem_req),   32'd0);
        check("s6_mem_addr",  32'(mem_addr),  32'd0);
        check("s6_mem_wdata", 32'(mem_wdata), 32'd0);
        check("s6_i_rdata",   32'(i_rdata),   32'd0);
        check("s6_d_rdata",   32'(d_rdata),   32'd0);
        check("s6_stall",     32'(stall),     32'd0);
        d_req   = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("s6_no_valid", 32'(d_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("s6_no_valid_after", 32'(d_valid), 32'd0);
        check("s6_idle_after",     32'(mem_req), 32'd0);
        d_req  = 1'b1;
        d_addr = 16'h0500;
        tick();
        check("s6_regrant_addr", 32'(mem_addr), 32'h0500);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (bus_err || $urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                quiet_inputs();
            end else begin
                rst_n     = 1'b1;
                hlt       = ($urandom_range(0, 9) == 0);
                i_req     = ($urandom_range(0, 99) < 60);
                d_req     = ($urandom_range(0, 99) < 35);
                d_we      = ($urandom_range(0, 1) == 1);
                i_addr    = 16'($urandom);
                d_addr    = 16'($urandom);
                d_wdata   = 16'($urandom);
                mem_rdata = 16'($urandom);
                if (mem_req) mem_ack = ($urandom_range(0, 99) < 55);
                else         mem_ack = ($urandom_range(0, 99) < 10);
            end
            tick();
        end

        rst_n = 1'b1;
        quiet_inputs();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter DW, default 16, data width in bits.
REQ-003 Parameter MAX_WAIT, default 15, maximum number of cycles to wait for mem_ack before a timeout is flagged; legal range is 1 to 255.
REQ-004 Port list, one port per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hlt  in  1  CPU halt; blocks new grants.
- i_req  in  1  instruction fetch request from the fetch stage.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched instruction.
- i_valid  out  1  one-cycle pulse: i_rdata is valid.
- d_req  in  1  data request from the memory stage.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  read data.
- d_valid  out  1  one-cycle pulse: data access is complete.
- stall  out  1  pipeline freeze to the CPU.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ack  in  1  memory completion, one cycle.
- bus_err  out  1  sticky timeout flag.

Function
REQ-005 The FSM SHALL have states IDLE, IBUSY, DBUSY and ERR.
REQ-006 In IDLE with hlt=0, d_req=1 SHALL win over i_req and move the FSM to DBUSY; otherwise i_req=1 SHALL move it to IBUSY.
REQ-007 On the grant edge, the SHALL latch the address, we and wdata into registers; mem_* SHALL be driven only from these registers.
REQ-008 mem_req SHALL be 1 in IBUSY and in DBUSY, and 0 in all other states.
REQ-009 mem_we SHALL equal the latched d_we in DBUSY and SHALL be 0 in every other state.
REQ-010 When mem_ack=1 in IBUSY: i_rdata SHALL take mem_rdata, i_valid SHALL pulse for the next cycle, and the FSM SHALL return to IDLE.
REQ-011 DBUSY SHALL complete the same way using d_rdata and d_valid; for writes, d_rdata SHALL hold its previous value.
REQ-012 A new grant SHALL be allowed in the cycle after the valid pulse, giving at least 3 cycles per access (grant, ack, valid/IDLE).
REQ-013 mem_ack SHALL be ignored in IDLE and in ERR.
REQ-014 A wait counter SHALL clear on each grant and increment each busy cycle without ack.
REQ-015 When the wait counter reaches MAX_WAIT, the FSM SHALL enter ERR and bus_err SHALL be set.
REQ-016 ERR SHALL be left only by reset.
REQ-017 stall SHALL be 1 when any of the following holds:
- (d_req or i_req) and no valid pulse is present this cycle;
- the FSM is busy;
- the FSM is in ERR.
REQ-018 hlt=1 SHALL block new grants only; an access in flight SHALL complete normally.
REQ-019 i_req and d_req arriving in the same IDLE cycle SHALL grant d; i SHALL be granted on the next idle opportunity if it is still asserted.
REQ-020 A request deasserted while its access is in flight SHALL NOT cancel the access.

Reset
REQ-021 On rst_n=0 the block SHALL asynchronously force: FSM to IDLE, wait counter to 0, and all outputs to 0 (i_rdata, d_rdata, mem_addr and mem_wdata all zero).
REQ-022 Reset during an access SHALL abort it with no valid pulse.
REQ-023 Release of rst_n SHALL take effect on the first following rising edge.

Structure
REQ-024 A shared package SHALL hold the state enum (arb_state_t), the AW/DW defaults, and the MAX_WAIT default.
REQ-025 The block SHALL be a single module with no sub-modules.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- i_req with addr 0x0010, ack after 2 cycles with rdata 0xBEEF -> i_valid pulses once, i_rdata=0xBEEF, stall high until the pulse.
- i_req and d_req rise together, d read 0x0200 -> mem_addr=0x0200 first, then 0x0010 after d_valid.
- d write addr 0x0040, wdata 0x1234 -> mem_we=1, mem_wdata=0x1234, d_valid pulses, d_rdata unchanged.
- hlt=1 during IBUSY -> fetch completes; no further mem_req while hlt=1.
- MAX_WAIT=4, no ack -> bus_err=1 after 4 busy cycles; stall stays 1 until rst_n.
- rst_n=0 mid-DBUSY -> all outputs 0 immediately, no d_valid, IDLE after release.
